// File: rtl/sys_weight_feeder.sv
// Weight-tile feeder: streams real rows and then zero padding into the systolic
// weight shift chain, and commits the tile with a single swap pulse once the array is idle.
module sys_weight_feeder #(
    parameter int ROWS   = 6,
    parameter int COLS   = 3,
    parameter int W_BW   = 8,
    parameter int CNT_BW = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(ROWS+1)-1:0] tile_rows,
    input  logic                      abort,
    input  logic                      w_in_valid,
    output logic                      w_in_ready,
    input  logic [COLS*W_BW-1:0]      w_in_data,
    output logic                      w_shift,
    output logic [COLS*W_BW-1:0]      w_out_data,
    input  logic                      compute_busy,
    output logic                      w_swap,
    output logic                      ready,
    output logic [CNT_BW-1:0]         tile_cnt
);
    localparam int            RB     = $clog2(ROWS+1);
    localparam logic [RB-1:0] ROWS_L = RB'(ROWS);
    localparam logic [RB-1:0] LAST_L = RB'(ROWS-1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_WAIT_SWAP} state_t;

    state_t                r_state, w_state_nxt;
    logic [RB-1:0]         r_n, w_n_nxt;
    logic [RB-1:0]         r_row_cnt, w_row_nxt, w_row_inc;
    logic [CNT_BW-1:0]     r_tile_cnt, w_cnt_nxt;
    logic [COLS*W_BW-1:0]  r_out_data, w_data_nxt;
    logic                  r_in_ready, r_shift, r_swap, r_ready;
    logic                  w_shift_nxt, w_swap_nxt, w_accept;

    assign w_accept  = w_in_valid && r_in_ready;
    assign w_row_inc = r_row_cnt + RB'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch behind.
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_row_nxt   = r_row_cnt;
        w_cnt_nxt   = r_tile_cnt;
        w_shift_nxt = 1'b0;
        w_swap_nxt  = 1'b0;
        w_data_nxt  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_n_nxt     = (tile_rows == '0 || tile_rows > ROWS_L) ? ROWS_L : tile_rows;
                    w_row_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_shift_nxt = 1'b1;
                    w_data_nxt  = w_in_data;
                    w_row_nxt   = w_row_inc;
                    if (w_row_inc == r_n)
                        w_state_nxt = (r_n == ROWS_L) ? S_WAIT_SWAP : S_PAD;
                end
            end
            S_PAD: begin
                // row_cnt keeps counting through the padding so the chain always sees ROWS shifts
                w_shift_nxt = 1'b1;
                w_row_nxt   = w_row_inc;
                if (r_row_cnt == LAST_L) w_state_nxt = S_WAIT_SWAP;
            end
            S_WAIT_SWAP: begin
                if (!compute_busy) begin
                    w_swap_nxt  = 1'b1;
                    w_cnt_nxt   = r_tile_cnt + CNT_BW'(1);
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_shift_nxt = 1'b0;
            w_swap_nxt  = 1'b0;
            w_data_nxt  = '0;
            w_cnt_nxt   = r_tile_cnt;
        end
    end

    // NOTE: state and outputs use non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n        <= ROWS_L;
            r_row_cnt  <= '0;
            r_tile_cnt <= '0;
            r_out_data <= '0;
            r_in_ready <= 1'b0;
            r_shift    <= 1'b0;
            r_swap     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_n        <= w_n_nxt;
            r_row_cnt  <= w_row_nxt;
            r_tile_cnt <= w_cnt_nxt;
            r_out_data <= w_data_nxt;
            r_in_ready <= (w_state_nxt == S_LOAD);
            r_shift    <= w_shift_nxt;
            r_swap     <= w_swap_nxt;
            r_ready    <= (w_state_nxt == S_IDLE);
        end
    end

    assign w_in_ready = r_in_ready;
    assign w_shift    = r_shift;
    assign w_out_data = r_out_data;
    assign w_swap     = r_swap;
    assign ready      = r_ready;
    assign tile_cnt   = r_tile_cnt;

endmodule

// File: tb/tb_sys_weight_feeder.sv
// Bench for sys_weight_feeder: a queue of expected chain rows is filled as tiles are driven
// and drained by a monitor that watches w_shift; swaps and the tile counter are tracked alongside.
module tb_sys_weight_feeder;
    localparam int ROWS   = 6;
    localparam int COLS   = 3;
    localparam int W_BW   = 8;
    localparam int CNT_BW = 2;
    localparam int RB     = $clog2(ROWS+1);
    localparam int DW     = COLS*W_BW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              w_in_valid = 1'b0;
    logic              compute_busy = 1'b0;
    logic [RB-1:0]     tile_rows = '0;
    logic [DW-1:0]     w_in_data = '0;
    logic              w_in_ready, w_shift, w_swap, ready;
    logic [DW-1:0]     w_out_data;
    logic [CNT_BW-1:0] tile_cnt;

    int                n_checks = 0;
    int                n_errors = 0;
    int                n_swaps  = 0;
    int                n_shifts = 0;
    logic [DW-1:0]     exp_q[$];
    logic [CNT_BW-1:0] exp_cnt = '0;

    sys_weight_feeder #(.ROWS(ROWS), .COLS(COLS), .W_BW(W_BW), .CNT_BW(CNT_BW)) dut (
        .clk(clk), .rst(rst), .start(start), .tile_rows(tile_rows), .abort(abort),
        .w_in_valid(w_in_valid), .w_in_ready(w_in_ready), .w_in_data(w_in_data),
        .w_shift(w_shift), .w_out_data(w_out_data), .compute_busy(compute_busy),
        .w_swap(w_swap), .ready(ready), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] row(input int k);
        return {COLS{W_BW'(k)}};
    endfunction

    // Scoreboard drain: every chain shift must match the oldest expected row.
    always @(negedge clk) begin
        if (rst) begin
            if (w_shift) begin
                n_shifts++;
                check("shift_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("shift_data", 32'(w_out_data), 32'(exp_q.pop_front()));
            end
            if (w_swap) begin
                n_swaps++;
                check("swap_after_all_shifts", 32'(exp_q.size()), 32'd0);
                check("swap_no_shift", 32'(w_shift), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int rows);
        tile_rows = RB'(rows);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready_low", 32'(ready), 32'd0);
        check("start_in_ready", 32'(w_in_ready), 32'd1);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input int gap);
        repeat (gap) tick();
        w_in_valid = 1'b1;
        w_in_data  = d;
        exp_q.push_back(d);
        tick();
        w_in_valid = 1'b0;
    endtask

    task automatic push_pads(input int n);
        repeat (ROWS - n) exp_q.push_back('0);
    endtask

    task automatic wait_swap(input int max_cycles, input string tag);
        logic got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            tick();
            got = w_swap;
        end
        check(tag, 32'(got), 32'd1);
        exp_cnt = exp_cnt + CNT_BW'(1);
        check("swap_tile_cnt", 32'(tile_cnt), 32'(exp_cnt));
        check("swap_ready", 32'(ready), 32'd1);
        tick();
        check("swap_one_cycle", 32'(w_swap), 32'd0);
    endtask

    initial begin
        int sw0;
        int sh0;

        @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_in_ready", 32'(w_in_ready), 32'd0);
        check("rst_shift", 32'(w_shift), 32'd0);
        check("rst_swap", 32'(w_swap), 32'd0);
        check("rst_data", 32'(w_out_data), 32'd0);
        check("rst_tile_cnt", 32'(tile_cnt), 32'd0);
        rst = 1'b1;
        tick();

        // Full tile, back-to-back rows, swap one cycle after the last shift
        start_tile(6);
        for (int k = 1; k <= 6; k++) send_beat(row(k), 0);
        check("full_in_ready_drop", 32'(w_in_ready), 32'd0);
        check("full_no_early_swap", 32'(w_swap), 32'd0);
        wait_swap(1, "full_swap");

        // Partial tile: two rows then four zero rows; a third offered row is refused
        start_tile(2);
        send_beat(row(7), 0);
        send_beat(row(8), 0);
        push_pads(2);
        w_in_valid = 1'b1;
        w_in_data  = row(9);
        check("partial_in_ready_drop", 32'(w_in_ready), 32'd0);
        tick();
        check("partial_in_ready_low", 32'(w_in_ready), 32'd0);
        w_in_valid = 1'b0;
        wait_swap(6, "partial_swap");

        // Deferred swap while the array is busy
        compute_busy = 1'b1;
        start_tile(6);
        for (int k = 11; k <= 16; k++) send_beat(row(k), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("defer_no_swap", 32'(w_swap), 32'd0);
        end
        compute_busy = 1'b0;
        wait_swap(1, "defer_swap");

        // Valid gaps stall the chain; a start during LOAD is ignored
        sh0 = n_shifts;
        start_tile(6);
        send_beat(row(21), 0);
        send_beat(row(22), 2);
        tile_rows = RB'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_start_ignored", 32'(ready), 32'd0);
        send_beat(row(23), 1);
        send_beat(row(24), 2);
        send_beat(row(25), 2);
        send_beat(row(26), 2);
        check("stall_in_ready_drop", 32'(w_in_ready), 32'd0);
        wait_swap(1, "stall_swap");
        check("stall_shift_total", 32'(n_shifts - sh0), 32'd6);

        // Abort after three rows; the beat offered with abort is not consumed
        sw0 = n_swaps;
        start_tile(6);
        for (int k = 31; k <= 33; k++) send_beat(row(k), 0);
        abort      = 1'b1;
        w_in_valid = 1'b1;
        w_in_data  = row(99);
        tick();
        abort      = 1'b0;
        w_in_valid = 1'b0;
        check("abort_load_ready", 32'(ready), 32'd1);
        check("abort_load_in_ready", 32'(w_in_ready), 32'd0);
        check("abort_load_shift", 32'(w_shift), 32'd0);
        repeat (3) tick();
        check("abort_load_queue", 32'(exp_q.size()), 32'd0);
        check("abort_load_swaps", 32'(n_swaps), 32'(sw0));
        check("abort_load_cnt", 32'(tile_cnt), 32'(exp_cnt));

        // Abort in the same cycle compute_busy falls: abort wins
        compute_busy = 1'b1;
        start_tile(6);
        for (int k = 41; k <= 46; k++) send_beat(row(k), 0);
        repeat (3) tick();
        abort        = 1'b1;
        compute_busy = 1'b0;
        tick();
        abort = 1'b0;
        check("abort_wait_swap", 32'(w_swap), 32'd0);
        check("abort_wait_ready", 32'(ready), 32'd1);
        repeat (3) tick();
        check("abort_wait_swaps", 32'(n_swaps), 32'(sw0));
        check("abort_wait_cnt", 32'(tile_cnt), 32'(exp_cnt));

        // Fifth commit with out-of-range tile_rows (clamps to a full tile) wraps the 2-bit counter to 1
        start_tile(7);
        for (int k = 51; k <= 56; k++) send_beat(row(k), 0);
        wait_swap(1, "clamp7_swap");
        check("wrap_cnt", 32'(tile_cnt), 32'd1);

        // Reset asserted mid-PAD
        start_tile(1);
        send_beat(row(61), 0);
        push_pads(1);
        tick();
        rst = 1'b0;
        #1;
        check("midpad_rst_ready", 32'(ready), 32'd1);
        check("midpad_rst_in_ready", 32'(w_in_ready), 32'd0);
        check("midpad_rst_shift", 32'(w_shift), 32'd0);
        check("midpad_rst_swap", 32'(w_swap), 32'd0);
        check("midpad_rst_data", 32'(w_out_data), 32'd0);
        check("midpad_rst_cnt", 32'(tile_cnt), 32'd0);
        exp_q.delete();
        exp_cnt = '0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(ready), 32'd1);

        // tile_rows=0 clamps to a full tile
        start_tile(0);
        for (int k = 71; k <= 76; k++) send_beat(row(k), 0);
        check("zero_rows_in_ready_drop", 32'(w_in_ready), 32'd0);
        wait_swap(1, "zero_rows_swap");

        repeat (2) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
